// File: rtl/ofs_fim_pcie_ss_tx_pkt_arb.sv
// ofs_fim_pcie_ss_tx_pkt_arb
//    Packet-atomic round-robin merge of NUM_REQ AXI-stream requesters onto a
//    single registered output stream. A requester that gets a non-last beat
//    accepted owns the output until its tlast beat is accepted. Once that
//    happens, the round-robin pointer moves to the requester after the owner.
//
// Ports
//    clk, rst           sole clock, synchronous active-high reset
//    in_tvalid/tready   per-requester handshake (NUM_REQ bits each)
//    in_tdata/tkeep/    per-requester payload, flattened; requester i
//    in_tlast/tuser       occupies slice [i*W +: W]
//    out_t*             merged stream, driven only from flops
//    out_grant_id       source index of the beat currently on out_*
//    pkt_cnt            per-requester count of accepted tlast beats
//                       (only when OFS_PCIE_SS_ARB_STATS_EN is defined)
//
// Build option
//    OFS_PCIE_SS_ARB_STATS_EN  adds the pkt_cnt port and its counters
//
// state  | meaning
// IDLE   | no owner; round-robin search from rr_ptr picks the grant
// LOCKED | owner is mid-packet; only the owner is granted
module ofs_fim_pcie_ss_tx_pkt_arb #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 512,
   parameter int USER_W  = 259,
   localparam int KEEP_W = DATA_W / 8,
   localparam int GID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         in_tvalid,
   output logic [NUM_REQ-1:0]         in_tready,
   input  logic [NUM_REQ*DATA_W-1:0]  in_tdata,
   input  logic [NUM_REQ*KEEP_W-1:0]  in_tkeep,
   input  logic [NUM_REQ-1:0]         in_tlast,
   input  logic [NUM_REQ*USER_W-1:0]  in_tuser,
   output logic                       out_tvalid,
   input  logic                       out_tready,
   output logic [DATA_W-1:0]          out_tdata,
   output logic [KEEP_W-1:0]          out_tkeep,
   output logic                       out_tlast,
   output logic [USER_W-1:0]          out_tuser,
   output logic [GID_W-1:0]           out_grant_id
`ifdef OFS_PCIE_SS_ARB_STATS_EN
   ,output logic [NUM_REQ*32-1:0]     pkt_cnt
`endif
);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t             state, state_nxt;
   logic [GID_W-1:0]   owner, owner_nxt;
   logic [GID_W-1:0]   rr_ptr, rr_ptr_nxt;
   logic [GID_W-1:0]   sel;
   logic [GID_W-1:0]   hi_idx, lo_idx;
   logic               hi_found, lo_found;
   logic               free;
   logic               accept;
   logic [NUM_REQ-1:0] grant;

   // Circular search split into two linear ones: the lowest valid index at or
   // above rr_ptr wins, otherwise wrap around to the lowest valid index overall.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = NUM_REQ-1; i >= 0; i--) begin
         if (in_tvalid[i]) begin
            lo_found = 1'b1;
            lo_idx   = GID_W'(i);
            if (GID_W'(i) >= rr_ptr) begin
               hi_found = 1'b1;
               hi_idx   = GID_W'(i);
            end
         end
      end
   end

   always_comb begin
      free       = !out_tvalid || out_tready;
      grant      = '0;
      sel        = owner;
      state_nxt  = state;
      owner_nxt  = owner;
      rr_ptr_nxt = rr_ptr;

      case (state)
         IDLE: begin
            sel = hi_found ? hi_idx : lo_idx;
            if (lo_found)
               grant[sel] = 1'b1;
         end
         LOCKED: grant[owner] = 1'b1;
      endcase

      in_tready = (free && !rst) ? grant : '0;
      accept    = |(in_tvalid & in_tready);

      if (accept) begin
         if (in_tlast[sel]) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = (sel == GID_W'(NUM_REQ-1)) ? '0 : sel + GID_W'(1);
         end else begin
            state_nxt = LOCKED;
            owner_nxt = sel;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         owner  <= '0;
         rr_ptr <= '0;
      end else begin
         state  <= state_nxt;
         owner  <= owner_nxt;
         rr_ptr <= rr_ptr_nxt;
      end
   end

   // Payload flops carry no reset; they are only meaningful while out_tvalid.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_tvalid   <= 1'b0;
         out_grant_id <= '0;
      end else if (accept) begin
         out_tvalid   <= 1'b1;
         out_tdata    <= in_tdata[sel*DATA_W +: DATA_W];
         out_tkeep    <= in_tkeep[sel*KEEP_W +: KEEP_W];
         out_tlast    <= in_tlast[sel];
         out_tuser    <= in_tuser[sel*USER_W +: USER_W];
         out_grant_id <= sel;
      end else if (out_tready) begin
         out_tvalid   <= 1'b0;
      end
   end

`ifdef OFS_PCIE_SS_ARB_STATS_EN
   logic acc_last;
   assign acc_last = accept && in_tlast[sel];

   always_ff @(posedge clk) begin
      if (rst)
         pkt_cnt <= '0;
      else if (acc_last)
         pkt_cnt[sel*32 +: 32] <= pkt_cnt[sel*32 +: 32] + 32'd1;
   end
`endif

endmodule

// File: tb/tb_ofs_fim_pcie_ss_tx_pkt_arb.sv
// Bench for ofs_fim_pcie_ss_tx_pkt_arb: random and directed packet sources, a
// transaction-level reference model, and a per-requester order scoreboard.
module tb_ofs_fim_pcie_ss_tx_pkt_arb;
   localparam int NR = 4;
   localparam int DW = 512;
   localparam int UW = 259;
   localparam int KW = DW / 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NR-1:0]     in_tvalid = '0;
   logic [NR-1:0]     in_tready;
   logic [NR*DW-1:0]  in_tdata = '0;
   logic [NR*KW-1:0]  in_tkeep = '0;
   logic [NR-1:0]     in_tlast = '0;
   logic [NR*UW-1:0]  in_tuser = '0;
   logic              out_tvalid;
   logic              out_tready = 1'b1;
   logic [DW-1:0]     out_tdata;
   logic [KW-1:0]     out_tkeep;
   logic              out_tlast;
   logic [UW-1:0]     out_tuser;
   logic [1:0]        out_grant_id;
`ifdef OFS_PCIE_SS_ARB_STATS_EN
   logic [NR*32-1:0]  pkt_cnt;
`endif

   ofs_fim_pcie_ss_tx_pkt_arb #(.NUM_REQ(NR), .DATA_W(DW), .USER_W(UW)) dut (
      .clk(clk), .rst(rst),
      .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata),
      .in_tkeep(in_tkeep), .in_tlast(in_tlast), .in_tuser(in_tuser),
      .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
      .out_tkeep(out_tkeep), .out_tlast(out_tlast), .out_tuser(out_tuser),
      .out_grant_id(out_grant_id)
`ifdef OFS_PCIE_SS_ARB_STATS_EN
      ,.pkt_cnt(pkt_cnt)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // stimulus configuration
   logic rst_q    = 1'b1;
   int   rdy_mode = 0;          // 0: out_tready always 1, 1: 15/16 duty
   int   vpct[NR];
   bit   en[NR];
   int   lenq[NR][$];
   int   gap_req = -1, gap_beat = 0, gap_left = 0;

   // source state
   bit            act[NR];
   int            beat[NR], seq[NR];
   logic [DW-1:0] s_data[NR];
   logic [KW-1:0] s_keep[NR];
   logic [UW-1:0] s_user[NR];
   bit            s_last[NR];

   // reference model: the beat that must sit on out_* after the next edge
   int            m_owner = -1, m_rr = 0, m_gid = 0;
   bit            m_valid = 0;
   logic [DW-1:0] m_data;
   logic [KW-1:0] m_keep;
   logic [UW-1:0] m_user;
   bit            m_last;
   int            m_cnt[NR];

   // scoreboard
   int exp_seq[NR], exp_beat[NR];
   int open_req = -1;
   int n_pkt = 0;
   int log_gid[$], log_cyc[$];
   bit snap_valid;

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
      end
   endtask

   task automatic chk_w(input string nm, input logic [DW-1:0] a, input logic [DW-1:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
      end
   endtask

   function automatic int mgrant();
      if (rst) return -1;
      if (m_owner >= 0) return m_owner;
      for (int k = 0; k < NR; k++)
         if (in_tvalid[(m_rr + k) % NR]) return (m_rr + k) % NR;
      return -1;
   endfunction

   task automatic consume();
      logic [31:0] tag;
      int r;
      tag = out_tdata[31:0];
      r   = int'(tag[31:24]) % NR;
      chk("sb_req_vs_gid", 64'(tag[31:24]), 64'(out_grant_id));
      if (open_req >= 0) chk("sb_no_interleave", 64'(r), 64'(open_req));
      chk("sb_seq", 64'(tag[23:8]), 64'(exp_seq[r]));
      chk("sb_beat", 64'(tag[7:0]), 64'(exp_beat[r]));
      log_gid.push_back(int'(out_grant_id));
      log_cyc.push_back(cyc);
      if (out_tlast) begin
         exp_seq[r]++;
         exp_beat[r] = 0;
         open_req = -1;
         n_pkt++;
      end else begin
         exp_beat[r]++;
         open_req = r;
      end
   endtask

   task automatic step();
      int g;
      bit free;
      logic [NR-1:0] et;
      logic [287:0] ut;
      @(negedge clk);
      cyc++;
      snap_valid = out_tvalid;
      chk("out_tvalid", 64'(out_tvalid), 64'(m_valid));
      chk("out_grant_id", 64'(out_grant_id), 64'(m_gid));
      if (m_valid) begin
         chk_w("out_tdata", out_tdata, m_data);
         chk_w("out_tkeep", DW'(out_tkeep), DW'(m_keep));
         chk_w("out_tuser", DW'(out_tuser), DW'(m_user));
         chk("out_tlast", 64'(out_tlast), 64'(m_last));
      end
`ifdef OFS_PCIE_SS_ARB_STATS_EN
      for (int i = 0; i < NR; i++) chk("pkt_cnt", 64'(pkt_cnt[i*32 +: 32]), 64'(m_cnt[i]));
`endif
      // drive
      rst = rst_q;
      out_tready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(15, 0) != 0);
      for (int i = 0; i < NR; i++) begin
         if (!act[i] && en[i] && lenq[i].size() > 0 && $urandom_range(99, 0) < vpct[i]) begin
            if (i == gap_req && beat[i] == gap_beat && gap_left > 0) begin
               gap_left--;
            end else begin
               act[i] = 1;
               for (int w = 0; w < DW/32; w++) s_data[i][w*32 +: 32] = $urandom;
               s_data[i][31:0] = {8'(i), 16'(seq[i]), 8'(beat[i])};
               s_keep[i] = {$urandom, $urandom};
               for (int w = 0; w < 9; w++) ut[w*32 +: 32] = $urandom;
               s_user[i] = ut[UW-1:0];
               s_last[i] = (beat[i] == lenq[i][0] - 1);
            end
         end
         in_tvalid[i]          = act[i];
         in_tdata[i*DW +: DW]  = s_data[i];
         in_tkeep[i*KW +: KW]  = s_keep[i];
         in_tuser[i*UW +: UW]  = s_user[i];
         in_tlast[i]           = s_last[i];
      end
      #1;
      g    = mgrant();
      free = !m_valid || out_tready;
      et   = (g >= 0 && free) ? (NR'(1) << g) : '0;
      chk("in_tready", 64'(in_tready), 64'(et));
      if (!rst && out_tvalid && out_tready) consume();
      for (int i = 0; i < NR; i++) begin
         if (in_tvalid[i] && in_tready[i]) begin
            act[i] = 0;
            if (s_last[i]) begin
               beat[i] = 0;
               seq[i]++;
               void'(lenq[i].pop_front());
            end else begin
               beat[i]++;
            end
         end
      end
      if (rst) begin
         for (int i = 0; i < NR; i++) begin
            if (beat[i] > 0) begin
               void'(lenq[i].pop_front());
               seq[i]++;
               beat[i] = 0;
               act[i]  = 0;
            end
            exp_seq[i]  = seq[i];
            exp_beat[i] = 0;
            m_cnt[i]    = 0;
         end
         open_req = -1;
         log_gid.delete();
         log_cyc.delete();
         m_owner = -1; m_rr = 0; m_valid = 0; m_gid = 0;
      end else if (g >= 0 && free && in_tvalid[g]) begin
         m_valid = 1;
         m_gid   = g;
         m_data  = in_tdata[g*DW +: DW];
         m_keep  = in_tkeep[g*KW +: KW];
         m_user  = in_tuser[g*UW +: UW];
         m_last  = in_tlast[g];
         if (in_tlast[g]) begin
            m_owner = -1;
            m_rr    = (g + 1) % NR;
            m_cnt[g]++;
         end else begin
            m_owner = g;
         end
      end else if (out_tready) begin
         m_valid = 0;
      end
   endtask

   task automatic reset_dut();
      rst_q = 1'b1;
      step();
      step();
      rst_q = 1'b0;
   endtask

   task automatic drain(input string nm, input int budget);
      int n;
      bit busy;
      n = 0;
      busy = 1;
      while (busy && n < budget) begin
         step();
         n++;
         busy = m_valid;
         for (int i = 0; i < NR; i++) if (lenq[i].size() > 0 || act[i]) busy = 1;
      end
      if (busy) begin
         total++;
         bad++;
         $display("FAIL %s: drain timeout after %0d cycles, expected idle", nm, budget);
      end
   endtask

   task automatic cfg_off();
      for (int i = 0; i < NR; i++) begin
         en[i] = 0;
         vpct[i] = 100;
         lenq[i].delete();
      end
      gap_req = -1;
      rdy_mode = 0;
   endtask

   task automatic chk_log(input string nm, input int exp_g[], input bit contig);
      chk({nm, "_count"}, 64'(log_gid.size()), 64'(exp_g.size()));
      for (int k = 0; k < exp_g.size(); k++) begin
         if (k < log_gid.size()) begin
            chk({nm, "_gid"}, 64'(log_gid[k]), 64'(exp_g[k]));
            if (contig) chk({nm, "_contig"}, 64'(log_cyc[k] - log_cyc[0]), 64'(k));
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int e032[] = '{0, 0, 0, 2, 2, 2};
      int e033[] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
      int e034[] = '{1, 1, 1, 1, 3, 3};
      int e036[] = '{1, 2, 2, 3};
      int n;

      for (int i = 0; i < NR; i++) begin
         act[i] = 0; beat[i] = 0; seq[i] = 0; m_cnt[i] = 0;
         exp_seq[i] = 0; exp_beat[i] = 0;
         s_data[i] = '0; s_keep[i] = '0; s_user[i] = '0; s_last[i] = 0;
      end
      m_data = '0; m_keep = '0; m_user = '0; m_last = 0;
      cfg_off();

      // two 3-beat packets offered together, sources already valid during reset
      lenq[0].push_back(3);
      lenq[2].push_back(3);
      en[0] = 1;
      en[2] = 1;
      reset_dut();
      chk("rst_out_tvalid", 64'(snap_valid), 64'd0);
      chk("rst_grant_id", 64'(out_grant_id), 64'd0);
      drain("t032", 100);
      chk_log("t032", e032, 1);

      // 1-beat packets from all requesters: strict rotation, no bubbles
      cfg_off();
      for (int i = 0; i < NR; i++) begin
         en[i] = 1;
         repeat (3) lenq[i].push_back(1);
      end
      reset_dut();
      drain("t033", 100);
      chk_log("t033", e033, 1);

      // owner gap keeps the lock while req3 waits
      cfg_off();
      lenq[1].push_back(4);
      lenq[3].push_back(2);
      en[1] = 1;
      en[3] = 1;
      gap_req = 1; gap_beat = 2; gap_left = 3;
      reset_dut();
      drain("t034", 100);
      chk_log("t034", e034, 0);
      if (log_cyc.size() >= 3) chk("t034_gap_seen", 64'(log_cyc[2] - log_cyc[1] > 1), 64'd1);

      // reset pulse in the middle of a 5-beat req2 packet
      cfg_off();
      lenq[2].push_back(1);
      lenq[2].push_back(5);
      lenq[2].push_back(2);
      lenq[1].push_back(1);
      lenq[3].push_back(1);
      en[2] = 1;
      reset_dut();
      n = 0;
      while (log_gid.size() < 1 && n < 50) begin step(); n++; end
      en[1] = 1;
      en[3] = 1;
      while (log_gid.size() < 3 && n < 100) begin step(); n++; end
      chk("t036_reached_beat2", 64'(log_gid.size()), 64'd3);
      rst_q = 1'b1;
      step();
      rst_q = 1'b0;
      step();
      chk("t036_out_tvalid_after_rst", 64'(snap_valid), 64'd0);
      drain("t036", 100);
      chk_log("t036", e036, 0);

      // long random run
      cfg_off();
      rdy_mode = 1;
      for (int i = 0; i < NR; i++) begin
         en[i] = 1;
         vpct[i] = $urandom_range(100, 40);
         repeat (2500) lenq[i].push_back($urandom_range(4, 1));
      end
      reset_dut();
      n_pkt = 0;
      drain("t035", 80000);
      chk("t035_packets", 64'(n_pkt), 64'd10000);

`ifdef OFS_PCIE_SS_ARB_STATS_EN
      cfg_off();
      en[1] = 1;
      en[3] = 1;
      repeat (7) lenq[1].push_back($urandom_range(3, 1));
      repeat (3) lenq[3].push_back($urandom_range(3, 1));
      reset_dut();
      drain("t037", 200);
      chk("t037_cnt0", 64'(pkt_cnt[31:0]), 64'd0);
      chk("t037_cnt1", 64'(pkt_cnt[63:32]), 64'd7);
      chk("t037_cnt2", 64'(pkt_cnt[95:64]), 64'd0);
      chk("t037_cnt3", 64'(pkt_cnt[127:96]), 64'd3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
